kd_tree_root_ctrl: RTL
======================

# kd_tree_root_ctrl

Build-pass sequencer that sits directly above the root `node` of the kd-tree and drives its top-side port. For each tree level it issues `configure_sort` (time-to-live plus sorting axis), then `start_sort`, and then waits for the root's `send_sort_ack`. It walks all levels of one build pass, reports completion or timeout, and is the only source of commands into the tree's top port.

## Interface
Parameters:
- `DIM`, 3: point dimensionality; the sorting axis cycles through 0..DIM-1.
- `DEPTH`, 4: tree levels processed per pass (1..255).
- `DATA_W`, 16: width of the data path into the root; must be ≥ AXIS_W+8.
- `CMD_W`, 3: command bus width.
- `TIMEOUT`, 1024: maximum cycles spent in WAIT_ACK before error.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a build pass; sampled in IDLE only.
- `alert_to_root` out 1: command beat valid; one-cycle pulse.
- `command_to_root` out CMD_W: command for the root `command_from_top`.
- `data_to_root` out DATA_W: payload for the root `data_from_top`.
- `alert_from_root` in 1: root command valid.
- `command_from_root` in CMD_W: root's upward command.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse when a pass completes.
- `error` out 1: sticky timeout flag.
- `level` out 8: level currently being sorted.

## Operation
- States: IDLE, CFG, START, WAIT_ACK, DONE.
- IDLE: on `start`, go to CFG. Set level=0, busy=1, error=0.
- CFG: drive a one-cycle beat with `alert_to_root`=1 and command=CMD_CONFIGURE_SORT. Data[AXIS_W-1:0] = level mod DIM. Data[AXIS_W+7:AXIS_W] = DEPTH-1-level (ttl). Remaining bits are 0. Next state is START.
- START: drive a one-cycle beat with command=CMD_START_SORT and data=0. Next state is WAIT_ACK with the timer cleared.
- WAIT_ACK: an ack is `alert_from_root`=1 with command=CMD_SEND_SORT_ACK.
  - On an ack at the last level (level==DEPTH-1), go to DONE.
  - On an ack at any other level, increment level and go to CFG.
  - Other root commands are ignored.
  - When the timer reaches TIMEOUT-1 with no ack, set error=1, clear busy and go to IDLE.
- DONE: pulse `done`=1 for one cycle, clear busy, return to IDLE. level holds its final value.
- Boundary cases:
  - `start` while busy is ignored.
  - An ack received in CFG or START is ignored and does not count.
  - An ack in the same cycle the timer expires: the ack wins.
  - DEPTH=1 gives a single CFG/START/WAIT_ACK sequence.
  - `rst` mid-pass returns everything to reset values at once; the root sees no further beats.
- Between beats, `alert_to_root`=0, command=CMD_NOP and data=0.

## Timing
- All outputs are registered.
- Reset values: `alert_to_root`=0, `command_to_root`=CMD_NOP, `data_to_root`=0, `busy`=0, `done`=0, `error`=0, `level`=0.
- `start` high at edge t produces:
  - busy=1 from t+1;
  - the configure beat visible in cycle t+1;
  - the start_sort beat in t+2;
  - WAIT_ACK from t+3.
- An ack sampled at edge a produces the next configure beat in a+1. On the last level it produces `done`=1 in a+1 and busy=0 in a+2.
- Minimum pass length: 3·DEPTH + 1 cycles plus the root's ack latency.
- The timer counts WAIT_ACK cycles only. Error is raised at the edge after TIMEOUT WAIT_ACK cycles.

## Structure
- Shared package `kd_tree_pkg` holds:
  - command encodings: CMD_NOP=0, CMD_CONFIGURE_SORT=1, CMD_START_SORT=2, CMD_WAIT_SORT_ACK=3, CMD_SEND_SORT_ACK=4, CMD_SWITCH_WITH_TOP=5, CMD_SWITCH_WITH_DOWN=6;
  - AXIS_W = clog2(DIM) (minimum 1);
  - the configure-payload field offsets.
- `node` and this block both import the package.
- One sub-module: `kd_timeout_counter`, a loadable down-counter with an expire flag.

## Test plan
- Full pass (DEPTH=4, DIM=3), root acks 5 cycles after each start_sort:
  - configure payloads ttl/axis = 3/0, 2/1, 1/2, 0/0;
  - exactly 4 start_sort beats;
  - one `done` pulse;
  - busy drops the cycle after `done`.
- No ack at level 2, TIMEOUT=16: error=1 and busy=0 after 16 WAIT_ACK cycles. The next `start` clears error and restarts at level 0.
- Ack driven during CFG and START beats, then no real ack: no level advance, and timeout fires.
- Ack and timer expiry in the same cycle: level advances, error stays 0.
- `start` pulsed during WAIT_ACK: no extra beats and level is unchanged.
- `rst` asserted between configure and start_sort beats: outputs zero asynchronously, no start_sort beat is emitted, and the block idles until the next `start`.

Source files
------------

// File: rtl/kd_tree_pkg.sv
// rtl/kd_tree_pkg.sv - shared kd-tree command encodings, sequencer states and payload layout
package kd_tree_pkg;

    localparam int CMD_NOP              = 0;
    localparam int CMD_CONFIGURE_SORT   = 1;
    localparam int CMD_START_SORT       = 2;
    localparam int CMD_WAIT_SORT_ACK    = 3;
    localparam int CMD_SEND_SORT_ACK    = 4;
    localparam int CMD_SWITCH_WITH_TOP  = 5;
    localparam int CMD_SWITCH_WITH_DOWN = 6;

    // Configure payload: axis in the low AXIS_W bits, 8-bit ttl directly above it.
    localparam int CFG_AXIS_LSB = 0;
    localparam int CFG_TTL_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG      = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } root_state_e;

    function automatic int axis_width(input int dim);
        return (dim <= 2) ? 1 : $clog2(dim);
    endfunction

    function automatic int cfg_ttl_lsb(input int dim);
        return CFG_AXIS_LSB + axis_width(dim);
    endfunction

endpackage

// File: rtl/kd_timeout_counter.sv
// rtl/kd_timeout_counter.sv - loadable down-counter that flags expiry when it reaches zero
module kd_timeout_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/kd_tree_root_ctrl.sv
// rtl/kd_tree_root_ctrl.sv - build-pass sequencer driving configure/start beats into the kd-tree root
module kd_tree_root_ctrl
    import kd_tree_pkg::*;
#(
    parameter int DIM     = 3,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 16,
    parameter int CMD_W   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              alert_to_root,
    output logic [CMD_W-1:0]  command_to_root,
    output logic [DATA_W-1:0] data_to_root,
    input  logic              alert_from_root,
    input  logic [CMD_W-1:0]  command_from_root,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        level
);

    localparam int AXIS_W  = axis_width(DIM);
    localparam int TTL_LSB = cfg_ttl_lsb(DIM);
    localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [7:0]        LAST_LEVEL = 8'(DEPTH - 1);
    localparam logic [AXIS_W-1:0] LAST_AXIS  = AXIS_W'(DIM - 1);
    localparam logic [CMD_W-1:0]  C_NOP      = CMD_W'(CMD_NOP);
    localparam logic [CMD_W-1:0]  C_CFG      = CMD_W'(CMD_CONFIGURE_SORT);
    localparam logic [CMD_W-1:0]  C_START    = CMD_W'(CMD_START_SORT);
    localparam logic [CMD_W-1:0]  C_ACK      = CMD_W'(CMD_SEND_SORT_ACK);

    root_state_e       state_q;
    logic              alert_q;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [7:0]        level_q;
    logic [AXIS_W-1:0] axis_q;

    logic              ack;
    logic              tmr_expired;
    logic [7:0]        level_d;
    logic [AXIS_W-1:0] axis_d;

    function automatic logic [DATA_W-1:0] cfg_payload(input logic [7:0] lvl,
                                                      input logic [AXIS_W-1:0] ax);
        logic [DATA_W-1:0] p;
        p = '0;
        p[CFG_AXIS_LSB +: AXIS_W]  = ax;
        p[TTL_LSB +: CFG_TTL_W]    = LAST_LEVEL - lvl;
        return p;
    endfunction

    assign ack = alert_from_root && (command_from_root == C_ACK);

    // Axis is tracked as a wrapping counter beside level, so no modulo is needed.
    assign level_d = level_q + 8'd1;
    assign axis_d  = (axis_q == LAST_AXIS) ? '0 : axis_q + 1'b1;

    kd_timeout_counter #(
        .W (TMR_W)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_START),
        .load_val_i (TMR_W'(TIMEOUT - 1)),
        .en_i       (state_q == ST_WAIT_ACK),
        .expired_o  (tmr_expired)
    );

    // Beat registers are written on the transition into a state, so each
    // beat is visible during the cycle the FSM spends in CFG or START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            alert_q <= 1'b0;
            cmd_q   <= C_NOP;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            level_q <= 8'd0;
            axis_q  <= '0;
        end else begin
            alert_q <= 1'b0;
            cmd_q   <= C_NOP;
            data_q  <= '0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_CFG;
                        level_q <= 8'd0;
                        axis_q  <= '0;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                        alert_q <= 1'b1;
                        cmd_q   <= C_CFG;
                        data_q  <= cfg_payload(8'd0, '0);
                    end
                end
                ST_CFG: begin
                    state_q <= ST_START;
                    alert_q <= 1'b1;
                    cmd_q   <= C_START;
                end
                ST_START: begin
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // An ack in the expiry cycle takes priority over the timeout.
                    if (ack) begin
                        if (level_q == LAST_LEVEL) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_CFG;
                            level_q <= level_d;
                            axis_q  <= axis_d;
                            alert_q <= 1'b1;
                            cmd_q   <= C_CFG;
                            data_q  <= cfg_payload(level_d, axis_d);
                        end
                    end else if (tmr_expired) begin
                        state_q <= ST_IDLE;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alert_to_root   = alert_q;
    assign command_to_root = cmd_q;
    assign data_to_root    = data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign level           = level_q;

endmodule
